// File: rtl/dtree_pkg.sv
// Shared types, default sizes, FSM encoding and node tables for the decision-tree sequencer.
package dtree_pkg;

    localparam int unsigned N_FEAT_D    = 16;
    localparam int unsigned FEAT_W_D    = 8;
    localparam int unsigned CLASS_W_D   = 4;
    localparam int unsigned NODE_W_D    = 6;
    localparam int unsigned MAX_DEPTH_D = 16;
    localparam int unsigned FIDX_W      = 5;
    localparam int unsigned TBL_DEPTH   = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EVAL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic                 is_leaf;
        logic [FIDX_W-1:0]    feat_idx;
        logic [FEAT_W_D-1:0]  thr;
        logic [NODE_W_D-1:0]  left;
        logic [NODE_W_D-1:0]  right;
        logic [CLASS_W_D-1:0] cls;
    } node_t;

    function automatic node_t mk_node(input int unsigned fidx, input int unsigned thr,
                                      input int unsigned l, input int unsigned r);
        node_t n;
        n          = '0;
        n.feat_idx = FIDX_W'(fidx);
        n.thr      = FEAT_W_D'(thr);
        n.left     = NODE_W_D'(l);
        n.right    = NODE_W_D'(r);
        return n;
    endfunction

    function automatic node_t mk_leaf(input int unsigned cls);
        node_t n;
        n         = '0;
        n.is_leaf = 1'b1;
        n.cls     = CLASS_W_D'(cls);
        return n;
    endfunction

    // Unpopulated entries decode as a non-leaf with an impossible feature index.
    localparam node_t BAD_NODE = mk_node(32'(2**FIDX_W - 1), 0, 0, 0);

    localparam node_t TREE0 [TBL_DEPTH] = '{
        mk_node(0, 127, 1, 2), mk_leaf(3), mk_leaf(7), BAD_NODE,
        BAD_NODE, BAD_NODE, BAD_NODE, BAD_NODE
    };

    // Deeper tree with a self-loop at node 5 and a branch to an unpopulated node 8.
    localparam node_t TREE1 [TBL_DEPTH] = '{
        mk_node(1, 50, 1, 2), mk_node(3, 200, 3, 4), mk_node(5, 10, 5, 8), mk_leaf(1),
        mk_node(15, 128, 7, 6), mk_node(0, 0, 5, 5), mk_leaf(12), mk_leaf(9)
    };

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node-table lookup; indices beyond the table return a bad-node record.
module dtree_node_rom
    import dtree_pkg::*;
#(
    parameter int unsigned TREE_ID = 0,
    parameter int unsigned NODE_W  = NODE_W_D
) (
    input  logic [NODE_W-1:0] node_idx,
    output node_t             node_rec_c
);

    localparam int unsigned TBL_IDX_W = $clog2(TBL_DEPTH);

    logic [TBL_IDX_W-1:0] tbl_idx;

    assign tbl_idx = node_idx[TBL_IDX_W-1:0];

    always_comb begin
        node_rec_c = BAD_NODE;
        if (node_idx < NODE_W'(TBL_DEPTH)) begin
            node_rec_c = (TREE_ID == 0) ? TREE0[tbl_idx] : TREE1[tbl_idx];
        end
    end

endmodule

// File: rtl/dtree_seq_ctrl.sv
// Streams in one feature vector, walks the decision tree one node per cycle and
// holds the class result until the consumer takes it.
module dtree_seq_ctrl
    import dtree_pkg::*;
#(
    parameter int unsigned N_FEAT    = N_FEAT_D,
    parameter int unsigned FEAT_W    = FEAT_W_D,
    parameter int unsigned CLASS_W   = CLASS_W_D,
    parameter int unsigned NODE_W    = NODE_W_D,
    parameter int unsigned MAX_DEPTH = MAX_DEPTH_D,
    parameter int unsigned TREE_ID   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               feat_valid,
    input  logic [FEAT_W-1:0]  feat_data,
    output logic               feat_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    output logic               busy
);

    localparam int unsigned CNT_W   = $clog2(N_FEAT);
    localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NODE_W-1:0]  node_q, node_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               out_valid_q, out_valid_d;
    logic [CLASS_W-1:0] out_class_q, out_class_d;
    logic               out_err_q, out_err_d;
    logic               busy_q, busy_d;
    logic               feat_ready_q, feat_ready_d;

    logic [FEAT_W-1:0]  feat_buf_q [N_FEAT];

    node_t              node_rec_c;
    logic [FEAT_W-1:0]  feat_sel_c;
    logic [FEAT_W-1:0]  thr_c;
    logic               go_left_c;
    logic               bad_c;
    logic               accept_c;

    dtree_node_rom #(
        .TREE_ID (TREE_ID),
        .NODE_W  (NODE_W)
    ) u_rom (
        .node_idx   (node_q),
        .node_rec_c (node_rec_c)
    );

    // Single time-shared comparator plus error detection for the current node.
    always_comb begin
        thr_c      = FEAT_W'(node_rec_c.thr);
        feat_sel_c = feat_buf_q[node_rec_c.feat_idx[CNT_W-1:0]];
        go_left_c  = (feat_sel_c <= thr_c);
        bad_c      = (depth_q == DEPTH_W'(MAX_DEPTH)) ||
                     (32'(node_rec_c.feat_idx) >= 32'(N_FEAT));
        accept_c   = feat_valid && feat_ready_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        node_d      = node_q;
        depth_d     = depth_q;
        out_class_d = out_class_q;
        out_err_d   = out_err_q;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept_c) begin
                    if (cnt_q == CNT_W'(N_FEAT - 1)) begin
                        state_d = S_EVAL;
                        cnt_d   = '0;
                        node_d  = '0;
                        depth_d = '0;
                    end else begin
                        state_d = S_LOAD;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_EVAL: begin
                if (node_rec_c.is_leaf) begin
                    out_class_d = CLASS_W'(node_rec_c.cls);
                    out_err_d   = 1'b0;
                    state_d     = S_DONE;
                end else if (bad_c) begin
                    out_class_d = '0;
                    out_err_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    node_d  = go_left_c ? NODE_W'(node_rec_c.left) : NODE_W'(node_rec_c.right);
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d  = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
        feat_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            node_q       <= '0;
            depth_q      <= '0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            feat_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            node_q       <= node_d;
            depth_q      <= depth_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_err_q    <= out_err_d;
            busy_q       <= busy_d;
            feat_ready_q <= feat_ready_d;
        end
    end

    // Feature storage carries no reset; every sample rewrites all entries before use.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            feat_buf_q[cnt_q] <= feat_data;
        end
    end

    assign feat_ready = feat_ready_q;
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign out_err    = out_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Directed and randomized checks of dtree_seq_ctrl on two trees using a result scoreboard.
module tb_dtree_seq_ctrl;

    typedef logic [7:0] feat_arr_t [16];

    typedef struct {
        logic [3:0] cls;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       fv   [2];
    logic [7:0] fd   [2];
    logic       fr   [2];
    logic       ov   [2];
    logic       ordy [2];
    logic [3:0] oc   [2];
    logic       oe   [2];
    logic       bsy  [2];

    exp_t q0 [$];
    exp_t q1 [$];

    int tests_run;
    int tests_failed;

    dtree_seq_ctrl #(.TREE_ID(0)) dut0 (
        .clk(clk), .rst(rst), .feat_valid(fv[0]), .feat_data(fd[0]), .feat_ready(fr[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_class(oc[0]), .out_err(oe[0]), .busy(bsy[0])
    );

    dtree_seq_ctrl #(.TREE_ID(1)) dut1 (
        .clk(clk), .rst(rst), .feat_valid(fv[1]), .feat_data(fd[1]), .feat_ready(fr[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_class(oc[1]), .out_err(oe[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent behavioural description of both trees.
    function automatic exp_t model(input int t, input feat_arr_t f);
        exp_t e;
        e.err = 1'b0;
        e.cls = 4'd0;
        if (t == 0) begin
            e.cls = (f[0] <= 8'd127) ? 4'd3 : 4'd7;
            e.lat = 2;
        end else if (f[1] <= 8'd50) begin
            if (f[3] <= 8'd200) begin
                e.cls = 4'd1;
                e.lat = 3;
            end else begin
                e.cls = (f[15] <= 8'd128) ? 4'd9 : 4'd12;
                e.lat = 4;
            end
        end else begin
            e.err = 1'b1;
            e.lat = (f[5] <= 8'd10) ? 17 : 3;
        end
        return e;
    endfunction

    task automatic send(input int t, input feat_arr_t f, input int nw, input int gap_pct, input bit push);
        logic acc;
        int   w;
        for (int i = 0; i < nw; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                fv[t] = 1'b0;
                @(posedge clk); #1;
            end
            fv[t] = 1'b1;
            fd[t] = f[i];
            acc   = 1'b0;
            w     = 0;
            while (!acc && w < 50) begin
                @(negedge clk);
                acc = fr[t];
                @(posedge clk); #1;
                w++;
            end
            if (!acc) check("feat_accept_timeout", 32'(acc), 32'd1);
        end
        fv[t] = 1'b0;
        if (push) begin
            if (t == 0) q0.push_back(model(t, f));
            else        q1.push_back(model(t, f));
        end
    endtask

    task automatic collect(input int t, input int hold);
        exp_t       e;
        int         lat;
        logic [3:0] c;
        logic       er;
        if ((t == 0 && q0.size() == 0) || (t == 1 && q1.size() == 0)) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e   = (t == 0) ? q0.pop_front() : q1.pop_front();
        lat = 0;
        while (!ov[t] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("t%0d_latency", t), 32'(lat), 32'(e.lat));
        check($sformatf("t%0d_class", t), 32'(oc[t]), 32'(e.cls));
        check($sformatf("t%0d_err", t), 32'(oe[t]), 32'(e.err));
        c  = oc[t];
        er = oe[t];
        for (int h = 0; h < hold; h++) begin
            fv[t]   = 1'b1;
            fd[t]   = 8'hA5;
            ordy[t] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("t%0d_hold_valid", t), 32'(ov[t]), 32'd1);
            check($sformatf("t%0d_hold_class", t), 32'(oc[t]), 32'(c));
            check($sformatf("t%0d_hold_err", t), 32'(oe[t]), 32'(er));
            check($sformatf("t%0d_hold_ready", t), 32'(fr[t]), 32'd0);
        end
        fv[t]   = 1'b0;
        ordy[t] = 1'b1;
        @(posedge clk); #1;
        ordy[t] = 1'b0;
        check($sformatf("t%0d_valid_drop", t), 32'(ov[t]), 32'd0);
        check($sformatf("t%0d_idle_busy", t), 32'(bsy[t]), 32'd0);
        check($sformatf("t%0d_class_retain", t), 32'(oc[t]), 32'(c));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 2; t++) begin
            check($sformatf("t%0d_rst_busy", t), 32'(bsy[t]), 32'd0);
            check($sformatf("t%0d_rst_valid", t), 32'(ov[t]), 32'd0);
            check($sformatf("t%0d_rst_ready", t), 32'(fr[t]), 32'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        feat_arr_t f;
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            fv[t]   = 1'b0;
            fd[t]   = 8'h00;
            ordy[t] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int t = 0; t < 2; t++) begin
            check($sformatf("t%0d_reset_ready", t), 32'(fr[t]), 32'd0);
            check($sformatf("t%0d_reset_busy", t), 32'(bsy[t]), 32'd0);
            check($sformatf("t%0d_reset_valid", t), 32'(ov[t]), 32'd0);
            check($sformatf("t%0d_reset_class", t), 32'(oc[t]), 32'd0);
            check($sformatf("t%0d_reset_err", t), 32'(oe[t]), 32'd0);
        end
        rst = 1'b0;

        // Basic tree: interior, above and exactly at the threshold.
        for (int i = 0; i < 16; i++) f[i] = 8'd0;
        f[0] = 8'd100;
        send(0, f, 16, 0, 1'b1);
        check("t0_busy_eval", 32'(bsy[0]), 32'd1);
        check("t0_ready_eval", 32'(fr[0]), 32'd0);
        collect(0, 0);
        f[0] = 8'd128;
        send(0, f, 16, 0, 1'b1);
        collect(0, 0);
        f[0] = 8'd127;
        send(0, f, 16, 0, 1'b1);
        collect(0, 0);

        // Consumer back-pressure while the result is held.
        f[0] = 8'd50;
        send(0, f, 16, 0, 1'b1);
        collect(0, 5);

        // Deeper tree: self-loop, unpopulated node, and three leaves.
        for (int i = 0; i < 16; i++) f[i] = 8'd0;
        f[1] = 8'd60; f[5] = 8'd5;
        send(1, f, 16, 0, 1'b1);
        collect(1, 0);
        f[5] = 8'd11;
        send(1, f, 16, 0, 1'b1);
        collect(1, 2);
        f[1] = 8'd50; f[3] = 8'd200;
        send(1, f, 16, 0, 1'b1);
        collect(1, 0);
        f[3] = 8'd201; f[15] = 8'd128;
        send(1, f, 16, 0, 1'b1);
        collect(1, 0);
        f[15] = 8'd129;
        send(1, f, 16, 0, 1'b1);
        collect(1, 0);

        // Reset in the middle of loading, then a fresh sample.
        for (int i = 0; i < 16; i++) f[i] = 8'd0;
        f[0] = 8'd200;
        send(0, f, 9, 0, 1'b0);
        pulse_reset();
        for (int i = 0; i < 16; i++) f[i] = 8'd255;
        f[0] = 8'd10;
        send(0, f, 16, 0, 1'b1);
        collect(0, 0);

        // Reset in the middle of a long evaluation, then a fresh sample.
        for (int i = 0; i < 16; i++) f[i] = 8'd0;
        f[1] = 8'd99; f[5] = 8'd0;
        send(1, f, 16, 0, 1'b0);
        repeat (5) @(posedge clk);
        pulse_reset();
        f[1] = 8'd7; f[3] = 8'd3; f[5] = 8'd200;
        send(1, f, 16, 0, 1'b1);
        collect(1, 0);

        // Random data, random input gaps and random consumer stalls.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 16; i++) f[i] = 8'($urandom_range(0, 255));
            send(k % 2, f, 16, 30, 1'b1);
            collect(k % 2, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
